// File: rtl/fft16_pkg.sv
// Shared types and helpers for the 16-point FFT frame controller.
package fft16_pkg;

   localparam int N_PTS  = 16;
   localparam int ADDR_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT
   } state_t;

   function automatic logic [ADDR_W-1:0] bitrev4(input logic [ADDR_W-1:0] a);
      return {a[0], a[1], a[2], a[3]};
   endfunction

endpackage

// File: rtl/fft16_frame_ctrl_if.sv
// Sample-in / bin-out stream bundle of the FFT frame controller.
interface fft16_frame_ctrl_if #(
   parameter int WIDTH = 16
);

   logic                         s_valid;
   logic                         s_ready;
   logic [WIDTH-1:0]             s_data;
   logic                         m_valid;
   logic                         m_ready;
   logic [WIDTH-1:0]             m_re;
   logic [WIDTH-1:0]             m_im;
   logic [fft16_pkg::ADDR_W-1:0] m_idx;
   logic                         m_last;

   // slave is the controller's view, master the surrounding system's view
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_re, m_im, m_idx, m_last
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_re, m_im, m_idx, m_last
   );

endinterface

// File: rtl/fft16_out_bank.sv
// Capture bank for the 16 complex bins, read mux and registered output stream.
module fft16_out_bank
   import fft16_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int OUT_BITREV = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   snap,
   input  logic [N_PTS*WIDTH-1:0] core_yr_flat,
   input  logic [N_PTS*WIDTH-1:0] core_yi_flat,
   input  logic                   m_ready,
   output logic                   m_valid,
   output logic [WIDTH-1:0]       m_re,
   output logic [WIDTH-1:0]       m_im,
   output logic [ADDR_W-1:0]      m_idx,
   output logic                   m_last,
   output logic                   last_hs,
   output logic [15:0]            frames_done
);

   logic [WIDTH-1:0]  bank_re_q [N_PTS];
   logic [WIDTH-1:0]  bank_re_d [N_PTS];
   logic [WIDTH-1:0]  bank_im_q [N_PTS];
   logic [WIDTH-1:0]  bank_im_d [N_PTS];
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  re_q, re_d;
   logic [WIDTH-1:0]  im_q, im_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic              last_q, last_d;
   logic [15:0]       frames_done_q, frames_done_d;
   logic              hs;
   logic [ADDR_W-1:0] rd_nxt;

   function automatic logic [ADDR_W-1:0] slot(input logic [ADDR_W-1:0] k);
      return (OUT_BITREV != 0) ? bitrev4(k) : k;
   endfunction

   assign hs      = valid_q & m_ready;
   assign last_hs = hs & (rd_cnt_q == ADDR_W'(N_PTS - 1));
   assign rd_nxt  = rd_cnt_q + ADDR_W'(1);

   always_comb begin
      bank_re_d     = bank_re_q;
      bank_im_d     = bank_im_q;
      valid_d       = valid_q;
      re_d          = re_q;
      im_d          = im_q;
      rd_cnt_d      = rd_cnt_q;
      last_d        = last_q;
      frames_done_d = frames_done_q;

      if (last_hs) begin
         frames_done_d = frames_done_q + 16'd1;
      end

      if (snap) begin
         for (int k = 0; k < N_PTS; k++) begin
            bank_re_d[k] = core_yr_flat[k*WIDTH +: WIDTH];
            bank_im_d[k] = core_yi_flat[k*WIDTH +: WIDTH];
         end
         // bin 0 sits in slot 0 in both natural and bit-reversed order
         valid_d  = 1'b1;
         re_d     = core_yr_flat[WIDTH-1:0];
         im_d     = core_yi_flat[WIDTH-1:0];
         rd_cnt_d = '0;
         last_d   = 1'b0;
      end else if (hs) begin
         rd_cnt_d = rd_nxt;
         re_d     = bank_re_q[slot(rd_nxt)];
         im_d     = bank_im_q[slot(rd_nxt)];
         last_d   = (rd_nxt == ADDR_W'(N_PTS - 1));
         if (last_hs) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_re_q     <= '{default: '0};
         bank_im_q     <= '{default: '0};
         valid_q       <= 1'b0;
         re_q          <= '0;
         im_q          <= '0;
         rd_cnt_q      <= '0;
         last_q        <= 1'b0;
         frames_done_q <= '0;
      end else begin
         bank_re_q     <= bank_re_d;
         bank_im_q     <= bank_im_d;
         valid_q       <= valid_d;
         re_q          <= re_d;
         im_q          <= im_d;
         rd_cnt_q      <= rd_cnt_d;
         last_q        <= last_d;
         frames_done_q <= frames_done_d;
      end
   end

   assign m_valid     = valid_q;
   assign m_re        = re_q;
   assign m_im        = im_q;
   assign m_idx       = rd_cnt_q;
   assign m_last      = last_q;
   assign frames_done = frames_done_q;

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point FFT: loads 16-sample frames into the input buffer,
// waits out the core latency and hands a bin snapshot to the output bank.
//
// state   | meaning
// ST_IDLE | first cycle after reset release
// ST_LOAD | accepting samples, writing the input buffer
// ST_WAIT | frame complete; core latency countdown, then wait for a free output bank
module fft16_frame_ctrl
   import fft16_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int CORE_LAT   = 2,
   parameter int OUT_BITREV = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   fft16_frame_ctrl_if.slave      bus,
   output logic                   buf_load,
   output logic [ADDR_W-1:0]      buf_addr,
   output logic [WIDTH-1:0]       buf_xr,
   input  logic [N_PTS*WIDTH-1:0] core_yr_flat,
   input  logic [N_PTS*WIDTH-1:0] core_yi_flat,
   output logic                   busy,
   output logic [15:0]            frames_done
);

   localparam int               LAT_W    = $clog2(CORE_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORE_LAT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic              buf_load_q, buf_load_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [WIDTH-1:0]  buf_xr_q, buf_xr_d;
   logic              busy_q, busy_d;
   logic              s_hs;
   logic              snap;
   logic              drain_active;
   logic              last_hs;

   assign bus.s_ready = (state_q == ST_LOAD);
   assign s_hs        = bus.s_valid & bus.s_ready;

   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      buf_load_d = 1'b0;
      buf_addr_d = buf_addr_q;
      buf_xr_d   = buf_xr_q;
      snap       = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_LOAD;
         ST_LOAD: begin
            if (s_hs) begin
               buf_load_d = 1'b1;
               buf_addr_d = wr_cnt_q;
               buf_xr_d   = bus.s_data;
               wr_cnt_d   = wr_cnt_q + ADDR_W'(1);
               if (wr_cnt_q == ADDR_W'(N_PTS - 1)) begin
                  state_d   = ST_WAIT;
                  lat_cnt_d = LAT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            // a drain finishing this very cycle frees the bank without a bubble
            if (lat_cnt_q != '0) begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end else if (!drain_active || last_hs) begin
               snap    = 1'b1;
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d    = ST_LOAD;
         wr_cnt_d   = '0;
         lat_cnt_d  = '0;
         buf_load_d = 1'b0;
         buf_addr_d = buf_addr_q;
         buf_xr_d   = buf_xr_q;
         snap       = 1'b0;
      end

      busy_d = (state_d != ST_IDLE) | snap | (drain_active & ~last_hs);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_cnt_q   <= '0;
         lat_cnt_q  <= '0;
         buf_load_q <= 1'b0;
         buf_addr_q <= '0;
         buf_xr_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         buf_load_q <= buf_load_d;
         buf_addr_q <= buf_addr_d;
         buf_xr_q   <= buf_xr_d;
         busy_q     <= busy_d;
      end
   end

   assign buf_load = buf_load_q;
   assign buf_addr = buf_addr_q;
   assign buf_xr   = buf_xr_q;
   assign busy     = busy_q;

   fft16_out_bank #(
      .WIDTH      (WIDTH),
      .OUT_BITREV (OUT_BITREV)
   ) u_out_bank (
      .clk          (clk),
      .rst          (rst),
      .snap         (snap),
      .core_yr_flat (core_yr_flat),
      .core_yi_flat (core_yi_flat),
      .m_ready      (bus.m_ready),
      .m_valid      (drain_active),
      .m_re         (bus.m_re),
      .m_im         (bus.m_im),
      .m_idx        (bus.m_idx),
      .m_last       (bus.m_last),
      .last_hs      (last_hs),
      .frames_done  (frames_done)
   );

   assign bus.m_valid = drain_active;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Bench for fft16_frame_ctrl: natural-order and bit-reversed instances share stimulus and
// are scored against a frame-level queue model fed by a stand-in core.
module tb_fft16_frame_ctrl;

   localparam int WIDTH    = 16;
   localparam int CORE_LAT = 2;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic s_valid;
   logic [15:0] s_data;
   logic m_ready;

   always #5 clk = ~clk;

   fft16_frame_ctrl_if #(.WIDTH(WIDTH)) if0 ();
   fft16_frame_ctrl_if #(.WIDTH(WIDTH)) if1 ();

   assign if0.s_valid = s_valid;
   assign if0.s_data  = s_data;
   assign if0.m_ready = m_ready;
   assign if1.s_valid = s_valid;
   assign if1.s_data  = s_data;
   assign if1.m_ready = m_ready;

   logic         buf_load0, buf_load1, busy0, busy1;
   logic [3:0]   buf_addr0, buf_addr1;
   logic [15:0]  buf_xr0, buf_xr1, fd0, fd1;
   logic [255:0] yr0, yi0, yr1, yi1;

   fft16_frame_ctrl #(.WIDTH(WIDTH), .CORE_LAT(CORE_LAT), .OUT_BITREV(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .bus(if0.slave),
      .buf_load(buf_load0), .buf_addr(buf_addr0), .buf_xr(buf_xr0),
      .core_yr_flat(yr0), .core_yi_flat(yi0), .busy(busy0), .frames_done(fd0)
   );

   fft16_frame_ctrl #(.WIDTH(WIDTH), .CORE_LAT(CORE_LAT), .OUT_BITREV(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .bus(if1.slave),
      .buf_load(buf_load1), .buf_addr(buf_addr1), .buf_xr(buf_xr1),
      .core_yr_flat(yr1), .core_yi_flat(yi1), .busy(busy1), .frames_done(fd1)
   );

   // stand-in core: not a real FFT, but order-sensitive and exact for an impulse
   function automatic logic [15:0] bin_re(input logic [15:0] x0, input logic [15:0] xk, input int k);
      return (k == 0) ? x0 : x0 + xk;
   endfunction

   function automatic logic [15:0] bin_im(input logic [15:0] xm, input int k);
      return (k == 0) ? 16'd0 : xm;
   endfunction

   function automatic int rev4i(input int k);
      return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
   endfunction

   logic [15:0] mem0 [16];
   logic [15:0] mem1 [16];

   always @(posedge clk) begin
      if (buf_load0) mem0[buf_addr0] <= buf_xr0;
      if (buf_load1) mem1[buf_addr1] <= buf_xr1;
   end

   always_comb begin
      yr0 = '0;
      yi0 = '0;
      yr1 = '0;
      yi1 = '0;
      for (int k = 0; k < 16; k++) begin
         yr0[k*16 +: 16]        = bin_re(mem0[0], mem0[k], k);
         yi0[k*16 +: 16]        = bin_im(mem0[(16-k) & 15], k);
         yr1[rev4i(k)*16 +: 16] = bin_re(mem1[0], mem1[k], k);
         yi1[rev4i(k)*16 +: 16] = bin_im(mem1[(16-k) & 15], k);
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   int          tick_n  = 0;
   int          full_tick = 0;
   int          fd_model = 0;
   logic [15:0] cur [$];
   logic [15:0] q_re [$];
   logic [15:0] q_im [$];
   int          q_idx [$];
   bit          exp_load = 1'b0;
   logic [3:0]  exp_addr = '0;
   logic [15:0] exp_xr = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // called at a falling edge with inputs already driven; ends on the next falling edge
   task automatic tick();
      bit s_hs;
      bit m_hs;
      if (rst) begin
         chk("buf_load", 32'(buf_load0), 32'(exp_load));
         if (exp_load) begin
            chk("buf_addr", 32'(buf_addr0), 32'(exp_addr));
            chk("buf_xr", 32'(buf_xr0), 32'(exp_xr));
         end
      end
      s_hs = s_valid & if0.s_ready;
      m_hs = if0.m_valid & m_ready;
      exp_load = s_hs & ~flush;
      if (flush) begin
         cur.delete();
      end else if (s_hs) begin
         exp_addr = 4'(cur.size());
         exp_xr   = s_data;
         cur.push_back(s_data);
         if (cur.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
               q_re.push_back(bin_re(cur[0], cur[k], k));
               q_im.push_back(bin_im(cur[(16-k) & 15], k));
               q_idx.push_back(k);
            end
            cur.delete();
            full_tick = tick_n;
         end
      end
      if (m_hs) begin
         if (q_re.size() == 0) begin
            chk("beat_unexpected", 32'(if0.m_valid), 32'd0);
         end else begin
            logic [15:0] er, ei;
            int ek;
            er = q_re.pop_front();
            ei = q_im.pop_front();
            ek = q_idx.pop_front();
            chk("m_re", 32'(if0.m_re), 32'(er));
            chk("m_im", 32'(if0.m_im), 32'(ei));
            chk("m_idx", 32'(if0.m_idx), 32'(ek));
            chk("m_last", 32'(if0.m_last), 32'(ek == 15));
            chk("br_m_valid", 32'(if1.m_valid), 32'd1);
            chk("br_m_re", 32'(if1.m_re), 32'(er));
            chk("br_m_im", 32'(if1.m_im), 32'(ei));
            chk("br_m_idx", 32'(if1.m_idx), 32'(ek));
            if (ek == 15) fd_model++;
         end
      end
      tick_n++;
      @(negedge clk);
   endtask

   task automatic feed(input int nacc, input int pv, input int pr, input int mode);
      int acc = 0;
      int n = 0;
      while (acc < nacc && n < 20000) begin
         s_valid = ($urandom_range(99) < pv);
         case (mode)
            1:       s_data = 16'(acc);
            2:       s_data = (acc % 16 == 0) ? 16'd1000 : 16'd0;
            default: s_data = 16'($urandom);
         endcase
         m_ready = ($urandom_range(99) < pr);
         if (s_valid && if0.s_ready) acc++;
         tick();
         n++;
      end
      s_valid = 1'b0;
      chk("feed_budget", 32'(acc), 32'(nacc));
   endtask

   task automatic drain(input int budget);
      int n = 0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      while ((q_re.size() != 0 || if0.m_valid) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", 32'(q_re.size()), 32'd0);
      chk("drain_frames_done", 32'(fd0), 32'(fd_model));
   endtask

   task automatic check_reset();
      chk("rst_m_valid", 32'(if0.m_valid), 32'd0);
      chk("rst_m_re", 32'(if0.m_re), 32'd0);
      chk("rst_m_im", 32'(if0.m_im), 32'd0);
      chk("rst_m_idx", 32'(if0.m_idx), 32'd0);
      chk("rst_m_last", 32'(if0.m_last), 32'd0);
      chk("rst_s_ready", 32'(if0.s_ready), 32'd0);
      chk("rst_buf_load", 32'(buf_load0), 32'd0);
      chk("rst_buf_addr", 32'(buf_addr0), 32'd0);
      chk("rst_buf_xr", 32'(buf_xr0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_frames_done", 32'(fd0), 32'd0);
      chk("rst_br_m_valid", 32'(if1.m_valid), 32'd0);
   endtask

   initial begin
      int n;
      int fd_start;
      rst     = 1'b0;
      flush   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      #1;
      check_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      tick();

      // ordered frame, latency from 16th handshake to first m_valid
      feed(16, 100, 100, 1);
      n = 0;
      m_ready = 1'b1;
      while (!if0.m_valid && n < 20) begin
         tick();
         n++;
      end
      chk("first_latency", 32'(tick_n - full_tick), 32'(2 + CORE_LAT));
      drain(100);
      chk("frames_done_1", 32'(fd0), 32'd1);

      // impulse frame
      feed(16, 100, 100, 2);
      drain(100);

      // output stall: second frame must hold in WAIT
      feed(16, 100, 0, 0);
      feed(16, 100, 0, 0);
      s_valid = 1'b1;
      m_ready = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      chk("stall_s_ready", 32'(if0.s_ready), 32'd0);
      chk("stall_m_valid", 32'(if0.m_valid), 32'd1);
      chk("stall_m_idx", 32'(if0.m_idx), 32'd0);
      chk("stall_busy", 32'(busy0), 32'd1);
      drain(200);
      chk("stall_frames", 32'(fd0), 32'd4);

      // random gaps on both sides
      fd_start = fd_model;
      feed(1600, 50, 50, 0);
      drain(400);
      chk("rand_frames", 32'(fd_model - fd_start), 32'd100);

      // flush of a partial frame while a drain is stalled
      feed(16, 100, 0, 0);
      feed(7, 100, 0, 0);
      s_valid = 1'b1;
      s_data  = 16'hDEAD;
      flush   = 1'b1;
      m_ready = 1'b0;
      tick();
      flush   = 1'b0;
      s_valid = 1'b0;
      tick();
      feed(16, 100, 0, 0);
      chk("flush_m_valid", 32'(if0.m_valid), 32'd1);
      chk("flush_m_idx", 32'(if0.m_idx), 32'd0);
      drain(200);

      // reset in the middle of a drain
      feed(16, 100, 100, 0);
      n = 0;
      m_ready = 1'b1;
      while (!(if0.m_valid && if0.m_idx == 4'd9) && n < 60) begin
         tick();
         n++;
      end
      chk("reach_bin9", 32'(if0.m_idx), 32'd9);
      m_ready = 1'b0;
      rst = 1'b0;
      #1;
      check_reset();
      cur.delete();
      q_re.delete();
      q_im.delete();
      q_idx.delete();
      exp_load = 1'b0;
      fd_model = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      tick();
      chk("post_rst_frames0", 32'(fd0), 32'd0);
      feed(16, 100, 100, 0);
      drain(100);
      chk("post_rst_frames1", 32'(fd0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
